// File: rtl/demux_pkg.sv
// Shared constants and types for the registered 1-to-8 demultiplexer.
// Used by both builds (with and without DEMUX_1TO8_PARITY_EN).
package demux_pkg;

  localparam int SEL_W   = 3;
  localparam int NUM_OUT = 8;

  typedef logic [SEL_W-1:0] sel_t;

  localparam logic [NUM_OUT-1:0] Y_RST = '0;

endpackage

// File: rtl/demux_1to8_if.sv
// Data/select/lane bundle for demux_1to8.
// y_par exists only when DEMUX_1TO8_PARITY_EN is defined.
interface demux_1to8_if
  import demux_pkg::*;
#(
  parameter int DATA_W = 1
);

  logic [DATA_W-1:0]         i;
  sel_t                      s;
  logic [NUM_OUT*DATA_W-1:0] y;
`ifdef DEMUX_1TO8_PARITY_EN
  logic                      y_par;

  modport master (output i, output s, input  y, input  y_par);
  modport slave  (input  i, input  s, output y, output y_par);
`else
  modport master (output i, output s, input  y);
  modport slave  (input  i, input  s, output y);
`endif

endinterface

// File: rtl/decoder_3to8.sv
// Combinational one-hot decoder: 3-bit select to an 8-bit lane-enable vector.
module decoder_3to8
  import demux_pkg::*;
(
  input  sel_t               s,
  output logic [NUM_OUT-1:0] onehot
);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_OUT; gi++) begin : g_dec
      assign onehot[gi] = (s == sel_t'(gi));
    end
  endgenerate

endmodule

// File: rtl/demux_1to8.sv
// Registered 1-to-8 demultiplexer: lane s gets i one cycle later, other lanes 0.
// Optional registered XOR parity of y when DEMUX_1TO8_PARITY_EN is defined.
module demux_1to8
  import demux_pkg::*;
#(
  parameter int DATA_W  = 1,
  parameter int NUM_OUT = 8
) (
  input  logic         clk,
  input  logic         rst,
  demux_1to8_if.slave  bus
);

  logic [NUM_OUT-1:0]        lane_sel;
  logic [NUM_OUT*DATA_W-1:0] y_next;
  logic [NUM_OUT*DATA_W-1:0] y_reg;

  decoder_3to8 u_dec (
    .s      (bus.s),
    .onehot (lane_sel)
  );

  // Each lane is the data gated by its decoder bit.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_OUT; gi++) begin : g_lane
      assign y_next[gi*DATA_W +: DATA_W] = bus.i & {DATA_W{lane_sel[gi]}};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      y_reg <= {DATA_W{Y_RST}};
    end else begin
      y_reg <= y_next;
    end
  end

  assign bus.y = y_reg;

`ifdef DEMUX_1TO8_PARITY_EN
  logic y_par_reg;

  // Parity of the value being loaded, so it lines up with y.
  always_ff @(posedge clk) begin
    if (rst) begin
      y_par_reg <= 1'b0;
    end else begin
      y_par_reg <= ^y_next;
    end
  end

  assign bus.y_par = y_par_reg;
`endif

endmodule

// File: tb/tb_demux_1to8.sv
// Scoreboard bench for demux_1to8 (DATA_W=1); parity checked when
// DEMUX_1TO8_PARITY_EN is defined.
module tb_demux_1to8;

  typedef struct {
    string      tag;
    logic [7:0] y;
    logic       par;
  } exp_t;

  logic clk;
  logic rst;
  int   checks   = 0;
  int   failures = 0;
  exp_t sb[$];

  demux_1to8_if #(.DATA_W(1)) bus ();

  demux_1to8 #(.DATA_W(1), .NUM_OUT(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Drive one transaction, push its expected result, wait for the edge,
  // then pop and compare away from the clock edge.
  task automatic step(input string tag, input logic r, input logic iv,
                      input logic [2:0] sv);
    exp_t e;
    exp_t got_e;
    logic [7:0] one;
    rst   = r;
    bus.i = iv;
    bus.s = sv;
    one   = 8'h01;
    e.tag = tag;
    e.y   = (r || !iv) ? 8'h00 : (one << sv);
    e.par = ^e.y;
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    got_e = sb.pop_front();
    check_val(got_e.tag, {24'h0, bus.y}, {24'h0, got_e.y});
`ifdef DEMUX_1TO8_PARITY_EN
    check_val({got_e.tag, "_par"}, {31'h0, bus.y_par}, {31'h0, got_e.par});
`endif
    $display("txn %s rst=%0b i=%0b s=%0d y=%02h exp=%02h",
             got_e.tag, r, iv, sv, bus.y, got_e.y);
  endtask

  initial begin
    rst   = 1'b1;
    bus.i = 1'b1;
    bus.s = 3'd5;

    step("rst0", 1'b1, 1'b1, 3'd5);
    step("rst1", 1'b1, 1'b1, 3'd5);

    for (int k = 0; k < 8; k++) step($sformatf("sweep%0d", k), 1'b0, 1'b1, 3'(k));
    for (int k = 0; k < 8; k++) step($sformatf("zero%0d", k), 1'b0, 1'b0, 3'(k));

    step("b2b_s3", 1'b0, 1'b1, 3'd3);
    step("b2b_s6", 1'b0, 1'b1, 3'd6);

    step("mid_run", 1'b0, 1'b1, 3'd7);
    step("mid_rst", 1'b1, 1'b1, 3'd7);
    step("mid_rel", 1'b0, 1'b1, 3'd7);

    for (int k = 0; k < 12; k++) begin
      step($sformatf("rand%0d", k), 1'b0, 1'($urandom_range(0, 1)),
           3'($urandom_range(0, 7)));
    end

    check_val("sb_empty", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
